// File: rtl/ps2_pkg.sv
// ps2_pkg: shared parser state encoding, scan-code prefix/ignored constants and frame record.
`default_nettype none

package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_t;

    localparam logic [7:0] c_PFX_E0 = 8'hE0;
    localparam logic [7:0] c_PFX_F0 = 8'hF0;
    localparam logic [7:0] c_PFX_E1 = 8'hE1;

    // Keyboard responses / errors that never form part of a key frame.
    localparam logic [7:0] c_IGN_FA = 8'hFA;
    localparam logic [7:0] c_IGN_AA = 8'hAA;
    localparam logic [7:0] c_IGN_EE = 8'hEE;
    localparam logic [7:0] c_IGN_FE = 8'hFE;
    localparam logic [7:0] c_IGN_00 = 8'h00;
    localparam logic [7:0] c_IGN_FF = 8'hFF;

    typedef struct packed {
        logic       valid;
        logic       is_break;
        logic       ext;
        logic [7:0] code;
    } ps2_frame_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == c_IGN_FA) || (b == c_IGN_AA) || (b == c_IGN_EE) ||
               (b == c_IGN_FE) || (b == c_IGN_00) || (b == c_IGN_FF);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_frame_parser.sv
// ps2_frame_parser: E0/F0 prefix FSM turning a byte stream into make/break frames.
// Optional prefix-abandon timeout enabled by macro PS2_KEY_TIMEOUT_EN.
`default_nettype none

module ps2_frame_parser
    import ps2_pkg::*;
#(
`ifdef PS2_KEY_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 50000
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_data_en,
    output ps2_frame_t o_frame,
    output logic       o_err
);

    ps2_state_t r_state;
    ps2_state_t w_state_nxt;
    logic       w_err_byte;
    logic       w_timeout;

`ifdef PS2_KEY_TIMEOUT_EN
    localparam int unsigned c_CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [c_CW-1:0] r_cnt;

    assign w_timeout = (r_state != ST_IDLE) && !i_data_en &&
                       (r_cnt == c_CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || i_data_en || (r_state == ST_IDLE) || w_timeout) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_frame     = '0;
        w_err_byte  = 1'b0;
        if (i_data_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_data == c_PFX_E0) begin
                        w_state_nxt = ST_EXT;
                    end else if (i_data == c_PFX_F0) begin
                        w_state_nxt = ST_BRK;
                    end else if (i_data == c_PFX_E1) begin
                        w_err_byte = 1'b1;
                    end else if (!is_ignored(i_data)) begin
                        o_frame = '{valid: 1'b1, is_break: 1'b0, ext: 1'b0, code: i_data};
                    end
                end
                ST_EXT: begin
                    if (i_data == c_PFX_F0) begin
                        w_state_nxt = ST_EXT_BRK;
                    end else if (i_data != c_PFX_E0) begin
                        o_frame     = '{valid: 1'b1, is_break: 1'b0, ext: 1'b1, code: i_data};
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    // An E0 after F0 is out of order: flag it and restart as an extended frame.
                    if (i_data == c_PFX_E0) begin
                        w_err_byte  = 1'b1;
                        w_state_nxt = ST_EXT;
                    end else if (i_data != c_PFX_F0) begin
                        o_frame     = '{valid: 1'b1, is_break: 1'b1,
                                        ext: (r_state == ST_EXT_BRK), code: i_data};
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    assign o_err = w_err_byte | w_timeout;

endmodule

`default_nettype wire

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: maps PS/2 set-2 make/break frames onto NUM_KEYS held/pulse channels.
// Macro PS2_KEY_TIMEOUT_EN enables abandoning stalled prefixes after TIMEOUT_CYCLES clocks.
`default_nettype none

module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned              NUM_KEYS       = 3,
    parameter logic [NUM_KEYS*9-1:0]    KEY_CODES      = {9'h023, 9'h01B, 9'h033},
    parameter int unsigned              TIMEOUT_CYCLES = 50000
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [7:0]          received_data,
    input  logic                received_data_en,
    output logic [NUM_KEYS-1:0] key_pulse,
    output logic [NUM_KEYS-1:0] key_held,
    output logic                any_held,
    output logic [8:0]          last_code,
    output logic                frame_err
);

    if ((NUM_KEYS < 1) || (NUM_KEYS > 16) || (TIMEOUT_CYCLES == 0)) begin : g_bad_param
        $error("ps2_key_decoder: NUM_KEYS must be 1..16 and TIMEOUT_CYCLES nonzero");
    end

    ps2_frame_t          w_frame;
    logic                w_err;
    logic [NUM_KEYS-1:0] w_match;
    logic [NUM_KEYS-1:0] w_held_nxt;
    logic [NUM_KEYS-1:0] w_pulse_nxt;
    logic [NUM_KEYS-1:0] r_key_pulse;
    logic [NUM_KEYS-1:0] r_key_held;
    logic [8:0]          r_last_code;
    logic                r_frame_err;

    ps2_frame_parser
`ifdef PS2_KEY_TIMEOUT_EN
        #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES))
`endif
    u_parser (
        .clk       (CLOCK_50),
        .rst       (reset),
        .i_data    (received_data),
        .i_data_en (received_data_en),
        .o_frame   (w_frame),
        .o_err     (w_err)
    );

    // The extended flag is part of the compare, so E0-prefixed codes never alias plain ones.
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_match
        assign w_match[gi] = w_frame.valid &&
                             (KEY_CODES[9*gi +: 9] == {w_frame.ext, w_frame.code});
    end

    always_comb begin
        w_held_nxt  = r_key_held;
        w_pulse_nxt = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (w_match[i]) begin
                if (w_frame.is_break) begin
                    w_held_nxt[i] = 1'b0;
                end else if (!r_key_held[i]) begin
                    w_held_nxt[i]  = 1'b1;
                    w_pulse_nxt[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_key_pulse <= '0;
            r_key_held  <= '0;
            r_last_code <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_key_pulse <= w_pulse_nxt;
            r_key_held  <= w_held_nxt;
            r_frame_err <= w_err;
            if (w_frame.valid) begin
                r_last_code <= {w_frame.ext, w_frame.code};
            end
        end
    end

    assign key_pulse = r_key_pulse;
    assign key_held  = r_key_held;
    assign any_held  = |r_key_held;
    assign last_code = r_last_code;
    assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed + randomized checks against a prefix-flag keyboard model.
`default_nettype none

module tb_ps2_key_decoder;

    localparam int NK = 5;
    localparam int TO = 100;
    // Channel 4 duplicates channel 0; channel 3 is an extended key.
    localparam logic [8:0] TBL [NK] = '{9'h033, 9'h01B, 9'h023, 9'h175, 9'h033};

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    received_data = 8'h00;
    logic          received_data_en = 1'b0;
    logic [NK-1:0] key_pulse;
    logic [NK-1:0] key_held;
    logic          any_held;
    logic [8:0]    last_code;
    logic          frame_err;

    ps2_key_decoder #(
        .NUM_KEYS       (NK),
        .KEY_CODES      ({9'h033, 9'h175, 9'h023, 9'h01B, 9'h033}),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLOCK_50         (clk),
        .reset            (reset),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .key_pulse        (key_pulse),
        .key_held         (key_held),
        .any_held         (any_held),
        .last_code        (last_code),
        .frame_err        (frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Keyboard model: pending-prefix flags plus expected outputs for the latest cycle.
    logic          m_ext, m_brk;
    logic [NK-1:0] m_held;
    logic [NK-1:0] exp_pulse;
    logic [8:0]    exp_last;
    logic          exp_err;

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = '0; exp_pulse = '0; exp_last = '0; exp_err = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_pulse = '0;
        exp_err   = 0;
        if (b == 8'hE0) begin
            if (m_brk) exp_err = 1;
            m_ext = 1; m_brk = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (!m_ext && !m_brk && (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            exp_err = 0;
        end else if (!m_ext && !m_brk && b == 8'hE1) begin
            exp_err = 1;
        end else begin
            for (int i = 0; i < NK; i++) begin
                if (TBL[i] == {m_ext, b}) begin
                    if (m_brk) m_held[i] = 0;
                    else if (!m_held[i]) begin m_held[i] = 1; exp_pulse[i] = 1; end
                end
            end
            exp_last = {m_ext, b};
            m_ext = 0; m_brk = 0;
        end
    endtask

    // One-cycle strobe; returns at the negedge right after the sampling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        received_data = b;
        received_data_en = 1'b1;
        @(negedge clk);
        received_data_en = 1'b0;
        received_data = 8'($urandom);
        model_byte(b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        received_data = 8'h1B;
        received_data_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        received_data_en = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        n_cmp++;
        if ({key_pulse, key_held, any_held, last_code, frame_err} !== '0) begin
            n_bad++;
            $display("FAIL reset: pulse=%b held=%b any=%b last=%h err=%b, required all zero",
                     key_pulse, key_held, any_held, last_code, frame_err);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_seq(input string name, input logic [7:0] seq[$]);
        foreach (seq[k]) begin
            send_byte(seq[k]);
            n_cmp++;
            if ({key_pulse, key_held, any_held, last_code, frame_err} !==
                {exp_pulse, m_held, |m_held, exp_last, exp_err}) begin
                n_bad++;
                $display("FAIL %s byte%0d=%h: pulse=%b held=%b any=%b last=%h err=%b, required pulse=%b held=%b any=%b last=%h err=%b",
                         name, k, seq[k], key_pulse, key_held, any_held, last_code, frame_err,
                         exp_pulse, m_held, |m_held, exp_last, exp_err);
            end
        end
    endtask

    task automatic test_make_repeat();
        test_seq("make_repeat", '{8'h33, 8'h33, 8'h33});
        n_cmp++;
        if (last_code !== 9'h033 || key_held[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL make_repeat_final: last=%h held0=%b, required 033 1", last_code, key_held[0]);
        end
    endtask

    task automatic test_break();
        test_seq("break", '{8'hF0, 8'h33});
        n_cmp++;
        if (any_held !== 1'b0 || key_pulse !== '0) begin
            n_bad++;
            $display("FAIL break_final: any=%b pulse=%b, required 0 00000", any_held, key_pulse);
        end
    endtask

    task automatic test_extended();
        test_seq("extended", '{8'h75, 8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75});
    endtask

    task automatic test_frame_err();
        test_seq("frame_err", '{8'h1B, 8'hF0, 8'hE0, 8'h1B, 8'hE1, 8'hFA, 8'hAA, 8'hF0, 8'h1B});
    endtask

    task automatic test_reset_mid();
        test_seq("reset_mid_a", '{8'h23, 8'hF0});
        do_reset();
        n_cmp++;
        if ({key_held, last_code, frame_err} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_clear: held=%b last=%h err=%b, required all zero",
                     key_held, last_code, frame_err);
        end
        test_seq("reset_mid_b", '{8'h23});
        n_cmp++;
        if (key_pulse[2] !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_pulse: pulse2=%b, required 1", key_pulse[2]);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        received_data = 8'hE0; received_data_en = 1'b1;
        @(negedge clk);
        model_byte(8'hE0);
        received_data = 8'h75;
        @(negedge clk);
        received_data_en = 1'b0;
        model_byte(8'h75);
        n_cmp++;
        if ({key_pulse, key_held, last_code} !== {exp_pulse, m_held, exp_last}) begin
            n_bad++;
            $display("FAIL back_to_back: pulse=%b held=%b last=%h, required pulse=%b held=%b last=%h",
                     key_pulse, key_held, last_code, exp_pulse, m_held, exp_last);
        end
        @(negedge clk);
        n_cmp++;
        if (key_pulse !== '0 || frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL back_to_back_idle: pulse=%b err=%b, required 0 0", key_pulse, frame_err);
        end
    endtask

    task automatic test_timeout();
        send_byte(8'hF0);
`ifdef PS2_KEY_TIMEOUT_EN
        repeat (TO - 1) @(negedge clk);
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: err=%b, required 0", frame_err);
        end
        @(negedge clk);
        n_cmp++;
        if (frame_err !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_fire: err=%b, required 1", frame_err);
        end
        m_ext = 0; m_brk = 0;
`else
        repeat (2 * TO) @(negedge clk);
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_absent: err=%b, required 0", frame_err);
        end
`endif
        test_seq("timeout_next", '{8'h1B});
    endtask

    task automatic test_random();
        logic [7:0] pool [12];
        logic [7:0] b;
        pool = '{8'hE0, 8'hF0, 8'h33, 8'h1B, 8'h23, 8'h75, 8'h14, 8'hE1, 8'hFA, 8'h00, 8'hFF, 8'hAA};
        for (int k = 0; k < 400; k++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 11)];
            send_byte(b);
            n_cmp++;
            if ({key_pulse, key_held, any_held, last_code, frame_err} !==
                {exp_pulse, m_held, |m_held, exp_last, exp_err}) begin
                n_bad++;
                $display("FAIL random#%0d byte=%h: pulse=%b held=%b any=%b last=%h err=%b, required pulse=%b held=%b any=%b last=%h err=%b",
                         k, b, key_pulse, key_held, any_held, last_code, frame_err,
                         exp_pulse, m_held, |m_held, exp_last, exp_err);
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                n_cmp++;
                if (key_pulse !== '0 || frame_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL random_idle#%0d: pulse=%b err=%b, required 0 0", k, key_pulse, frame_err);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_make_repeat();
        test_break();
        test_extended();
        test_frame_err();
        test_reset_mid();
        test_back_to_back();
        test_timeout();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter NUM_KEYS, default 3, number of decoded key channels (1..16).
REQ-002 Parameter KEY_CODES, default {9'h023, 9'h01B, 9'h033}, NUM_KEYS*9-bit packed table; channel i = bits [9i+8:9i]; bit 8 = extended (E0) flag, bits 7:0 = set-2 scan code.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, prefix-abandon limit in clocks (only with PS2_KEY_TIMEOUT_EN).
REQ-004 CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 received_data  input  8  byte from PS2_Controller.
REQ-007 received_data_en  input  1  one-cycle strobe: received_data is valid.
REQ-008 key_pulse  output  NUM_KEYS  one-cycle strobe per channel on a fresh make.
REQ-009 key_held  output  NUM_KEYS  level: channel currently pressed.
REQ-010 any_held  output  1  OR of key_held.
REQ-011 last_code  output  9  {ext, code} of the most recent completed make/break frame, any key.
REQ-012 frame_err  output  1  one-cycle strobe on a discarded/malformed frame.

Function
REQ-013 Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen); transitions only on received_data_en.
REQ-014 IDLE: E0->EXT; F0->BRK; FA, AA, EE, FE, 00, FF ignored, stay IDLE; E1 -> frame_err, stay IDLE; other byte = make {0,byte}.
REQ-015 EXT: F0->EXT_BRK; E0 stays EXT; other byte = make {1,byte}, ->IDLE.
REQ-016 BRK: F0 stays BRK; E0 -> frame_err, ->EXT; other byte = break {0,byte}, ->IDLE.
REQ-017 EXT_BRK: F0 stays; E0 -> frame_err, ->EXT; other byte = break {1,byte}, ->IDLE.
REQ-018 Make of code matching channel i with key_held[i]=0: key_pulse[i]=1 and key_held[i]=1 on the cycle after the strobe (latency 1).
REQ-019 Make with key_held[i]=1 (typematic repeat): no pulse, held unchanged.
REQ-020 Break matching channel i: key_held[i]=0 one cycle after strobe; no pulse; break of an un-held key has no effect.
REQ-021 Duplicate table entries: every matching channel responds identically.
REQ-022 Extended flag must match exactly: {1,0x14} never matches entry {0,0x14}.
REQ-023 last_code updates on every completed make/break frame, matched or not; unchanged by prefixes and ignored bytes.
REQ-024 key_pulse, frame_err are zero on every cycle without a qualifying event; multiple channels may pulse together.
REQ-025 received_data and received_data_en are ignored while reset is high.

Reset
REQ-026 On reset: FSM=IDLE, key_pulse=0, key_held=0, any_held=0, last_code=0, frame_err=0, timeout counter=0.
REQ-027 Reset mid-frame (e.g. after F0) discards the partial frame; next byte is parsed from IDLE.

Configuration
REQ-028 Macro PS2_KEY_TIMEOUT_EN defined: counter runs while FSM not IDLE, clears on each strobe; reaching TIMEOUT_CYCLES with no strobe forces IDLE and pulses frame_err.
REQ-029 PS2_KEY_TIMEOUT_EN undefined: no counter; FSM waits in prefix state indefinitely; TIMEOUT_CYCLES unused.

Structure
REQ-030 Shared package ps2_pkg holds FSM state encoding, prefix constants (E0, F0, E1) and ignored-code constants (FA, AA, EE, FE, 00, FF).
REQ-031 One sub-module ps2_frame_parser (FSM + timeout) emits {valid, is_break, ext, code}; top level holds channel matching and held/pulse registers.
REQ-032 No instance of PS2_Controller inside this block; the byte stream is an input.

Verification
REQ-033 Default params; bytes 33, 33, 33 -> one key_pulse[0] one cycle after first strobe; key_held[0]=1 throughout; last_code=0x033.
REQ-034 Bytes 33, F0, 33 -> key_held[0] falls one cycle after last strobe; no pulse on break; any_held=0.
REQ-035 Table entry {1,0x75}; bytes 75 then E0 75 -> only the E0 75 frame pulses; last_code=0x175 then.
REQ-036 Bytes F0, E0, 1B -> frame_err pulse after E0; 1B parsed as extended make {1,1B}, no match for S entry; key_held unchanged.
REQ-037 Bytes 23 then reset asserted for 1 cycle mid-sequence after F0, then 23 -> key_held[2] cleared by reset, second 23 yields fresh pulse.
REQ-038 With PS2_KEY_TIMEOUT_EN, TIMEOUT_CYCLES=100: F0 then 100 idle cycles -> frame_err pulse, FSM IDLE; subsequent 1B pulses key_pulse[1].
